// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, single-outstanding instruction-memory requests and a small
// instruction buffer toward decode. Optional build macro: FETCH_ALIGN_CHECK_EN.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        flush,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        instr_valid_d,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misaligned_d,
`endif
    input  logic        instr_ready_d
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t            state_r;
    logic [31:0]       pc_r;
    logic [31:0]       pc_req_r;
    logic              outstanding_r;
    logic              kill_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [31:0]       fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]       fifo_instr_r [FIFO_DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic              fifo_mis_r   [FIFO_DEPTH];
    logic              push_mis_s;
`endif

    logic [CNT_W-1:0]  occ_s;
    logic              room_s;
    logic              req_valid_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              instr_valid_s;
    logic [31:0]       push_pc_s;
    logic [31:0]       push_instr_s;

    // Occupancy counts the in-flight request so a response always finds a free slot.
    assign occ_s         = count_r + {{(CNT_W-1){1'b0}}, outstanding_r};
    assign room_s        = (occ_s < DEPTH_C);
    assign instr_valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s         = instr_valid_s && instr_ready_d;
    assign accept_s      = req_valid_s && imem_req_ready;

    // Request generation and selection of the entry to push this cycle.
    always_comb begin
        req_valid_s  = 1'b0;
        push_s       = 1'b0;
        push_pc_s    = pc_req_r;
        push_instr_s = imem_resp_data;
`ifdef FETCH_ALIGN_CHECK_EN
        push_mis_s   = 1'b0;
`endif
        case (state_r)
            ST_FETCH: begin
                if (reset || flush) begin
                    req_valid_s = 1'b0;
                end
`ifdef FETCH_ALIGN_CHECK_EN
                else if (pc_r[1:0] != 2'b00) begin
                    push_s       = room_s;
                    push_pc_s    = pc_r;
                    push_instr_s = NOP_INSTR;
                    push_mis_s   = 1'b1;
                end
`endif
                else begin
                    req_valid_s = room_s;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid && !kill_r && !flush) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                req_valid_s = 1'b0;
                push_s      = 1'b0;
            end
        endcase
    end

    // Fetch control FSM: PC, outstanding-request tracking and response kill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            pc_req_r      <= 32'h0000_0000;
            outstanding_r <= 1'b0;
            kill_r        <= 1'b0;
        end else if (flush) begin
            pc_r <= pc_next;
            // A response landing in the flush cycle closes the transaction itself.
            if ((state_r == ST_WAIT) && !imem_resp_valid) begin
                state_r       <= ST_WAIT;
                outstanding_r <= 1'b1;
                kill_r        <= 1'b1;
            end else begin
                state_r       <= ST_FETCH;
                outstanding_r <= 1'b0;
                kill_r        <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (accept_s) begin
                        pc_r          <= pc_next;
                        pc_req_r      <= pc_r;
                        outstanding_r <= 1'b1;
                        state_r       <= ST_WAIT;
                    end else if (push_s) begin
                        pc_r <= pc_next;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        outstanding_r <= 1'b0;
                        kill_r        <= 1'b0;
                        state_r       <= ST_FETCH;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r       <= ST_FETCH;
                    outstanding_r <= 1'b0;
                    kill_r        <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer: circular FIFO, cleared on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
                fifo_mis_r[i]   <= 1'b0;
`endif
            end
        end else if (flush) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= push_pc_s;
                fifo_instr_r[wr_ptr_r] <= push_instr_s;
`ifdef FETCH_ALIGN_CHECK_EN
                fifo_mis_r[wr_ptr_r]   <= push_mis_s;
`endif
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pc_f           = pc_r;
    assign pc_plus4_f     = pc_r + 32'd4;
    assign imem_req_valid = req_valid_s;
    assign instr_d        = fifo_instr_r[rd_ptr_r];
    assign pc_d           = fifo_pc_r[rd_ptr_r];
    assign instr_valid_d  = instr_valid_s;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned_d   = fifo_mis_r[rd_ptr_r];
`endif

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Fetch stage that sits directly downstream of the next-PC mux2.
- Holds the PC register and drives pc_plus4_f, which feeds the mux2 d0 input. The branch target feeds d1 and pc_src drives select.
- Consumes the mux2 output y as pc_next, issues single-outstanding instruction-memory requests, and buffers returned instructions in a small FIFO toward decode.
- Flush (branch taken) drops in-flight and buffered instructions and redirects the PC.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_next  input  32  mux2 output y (pc_plus4_f or branch target).
- flush  input  1  redirect: branch taken, same as the mux2 select.
- pc_f  output  32  current fetch address.
- pc_plus4_f  output  32  pc_f + 4, goes to mux2 d0.
- imem_req_valid  output  1  request valid; address is pc_f.
- imem_req_ready  input  1  memory accepts request.
- imem_resp_valid  input  1  instruction data valid.
- imem_resp_data  input  32  instruction word.
- instr_d  output  32  FIFO head instruction.
- pc_d  output  32  PC of FIFO head.
- instr_valid_d  output  1  FIFO not empty.
- instr_ready_d  input  1  decode consumes the head.

Behaviour:
- Reset (async, active-high):
  - pc_f = RESET_PC.
  - FIFO empty: count 0, read and write pointers 0.
  - state = FETCH; outstanding = 0; kill = 0.
  - imem_req_valid = 0 while reset is high; instr_valid_d = 0; instr_d/pc_d = 0.
  - Reset mid-transaction abandons everything; any response arriving after reset deasserts with outstanding = 0 is ignored.
- pc_plus4_f = pc_f + 32'd4, combinational; wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- States:
  - FETCH: imem_req_valid = (count + outstanding < FIFO_DEPTH) && !flush.
    - On req_valid && req_ready: pc_f <= pc_next, the pc of the accepted request is latched as pc_req, outstanding <= 1, go to WAIT.
  - WAIT: imem_req_valid = 0.
    - On imem_resp_valid: push {pc_req, imem_resp_data} unless kill is set; outstanding <= 0, kill <= 0, go to FETCH.
    - A response may arrive one or more cycles after acceptance; zero-cycle (same-cycle) responses are not supported.
- Latency: with memory ready and a 1-cycle response, data is visible on instr_d 2 cycles after the request is accepted. Steady-state throughput is one instruction every 2 cycles.
- FIFO:
  - Push and pop in the same cycle are both allowed and leave count unchanged.
  - Pop occurs when instr_valid_d && instr_ready_d. Pop when empty is a no-op.
  - Push never occurs when full; the room check guarantees this.
- Flush, highest priority:
  - pc_f <= pc_next in that cycle, regardless of handshake state.
  - FIFO cleared: count 0, pointers 0. instr_valid_d is 0 from the next cycle.
  - imem_req_valid is forced 0 in the flush cycle.
  - If outstanding, or a request is accepted in the flush cycle: kill <= 1, state stays or becomes WAIT, and the matching response is discarded.
  - If a response arrives in the flush cycle, it is discarded.
  - A flush in FETCH with nothing outstanding stays in FETCH.
- Simultaneous pop and flush: flush wins; the pop is irrelevant.
- Backpressure: decode stall (instr_ready_d = 0) fills the FIFO. Requests stop once count + outstanding = FIFO_DEPTH. pc_f holds.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_d (1 bit), stored per FIFO entry.
  - In FETCH, if pc_f[1:0] != 0, no memory request is issued. Instead, when room exists, an entry {pc_f, 32'h00000013, misaligned = 1} is pushed directly, and pc_f <= pc_next.
  - Normal entries carry misaligned = 0.
- Undefined:
  - No misaligned_d port.
  - pc_f[1:0] are ignored; the address is sent to memory unchanged.

Test Plan:
- Reset with RESET_PC = 32'h100, memory always ready, 1-cycle response -> pc_d sequence 0x100, 0x104, 0x108 with matching instr_d; pc_plus4_f = 0x104 while pc_f = 0x100.
- Decode held off (instr_ready_d = 0) for 10 cycles, FIFO_DEPTH = 2 -> exactly 2 entries buffered, imem_req_valid low, pc_f frozen at 0x108; releasing drains 0x100 then 0x104.
- Flush with pc_next = 0x200 while a response for 0x108 is outstanding -> 0x108 data discarded, FIFO empty the next cycle, next pc_d = 0x200.
- imem_req_ready held low 5 cycles -> pc_f stable, imem_req_valid held high; pc_f advances on the first ready cycle.
- Assert reset while in WAIT -> all outputs return to reset values immediately; a stale response arriving afterward is not pushed.
- FETCH_ALIGN_CHECK_EN defined, flush to 0x202 -> entry pc_d = 0x202, instr_d = 0x00000013, misaligned_d = 1, no imem request for it.
